freelist: RTL and testbench
===========================

FREELIST -- requirements
Module: freelist

Interface
REQ-001 SHALL have parameter NUM_PREGS, default 64, meaning physical register count; preg width is `PREG_RANGE (6 bits).
REQ-002 SHALL have parameter DEPTH, default 32, meaning queue entries, equal to NUM_PREGS minus 32 architectural registers.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port alloc0_req  input  1  rename slot 0 needs a new preg.
REQ-006 SHALL have port alloc1_req  input  1  rename slot 1 needs a new preg.
REQ-007 SHALL have port alloc_ready  output  1  at least 2 free pregs exist, so both slots may allocate.
REQ-008 SHALL have port alloc0_preg  output  6  preg granted to slot 0.
REQ-009 SHALL have port alloc1_preg  output  6  preg granted to slot 1.
REQ-010 SHALL have port commits0_valid  input  1  commit slot 0 valid.
REQ-011 SHALL have port commits0_need_to_wb  input  1  commit slot 0 wrote a logical register.
REQ-012 SHALL have port commits0_old_prd  input  6  preg previously mapped to slot 0's lrd; freed at commit.
REQ-013 SHALL have ports commits1_valid, commits1_need_to_wb, commits1_old_prd, with the same widths and meaning for commit slot 1.
REQ-014 SHALL have port flush_valid  input  1  pipeline redirect; discard speculative allocations.
REQ-015 SHALL have port free_count  output  6  free pregs available to rename, range 0..32.

Function
REQ-016 SHALL hold DEPTH entries of 6 bits in a circular queue.
REQ-017 SHALL keep three 6-bit pointers (5-bit index plus wrap bit):
  - spec_head: speculative allocation pointer.
  - arch_head: allocation pointer as of the last commit.
  - tail: free-insertion pointer.
REQ-018 SHALL define free_count = tail - spec_head, modulo 64.
REQ-019 SHALL assert alloc_ready combinationally when free_count >= 2; allocation is all-or-nothing.
REQ-020 SHALL drive alloc0_preg = queue[spec_head].
REQ-021 SHALL drive alloc1_preg = queue[spec_head+1] when alloc0_req=1, else queue[spec_head].
REQ-022 SHALL grant allocation when alloc_ready=1 and flush_valid=0.
  - On grant, spec_head advances by alloc0_req+alloc1_req (0..2) at the next edge.
  - Requests while alloc_ready=0 are ignored; the pointer is unchanged.
REQ-023 SHALL treat commit slot i as freeing when commitsi_valid & commitsi_need_to_wb.
REQ-024 SHALL insert freed pregs in program order:
  - Slot 0 writes queue[tail], then slot 1 writes the next entry.
  - If only slot 1 frees, it writes queue[tail].
  - tail advances by the number of frees.
REQ-025 SHALL advance arch_head by the same number of frees in the same cycle, since each writing commit consumed one allocation.
REQ-026 SHALL, on flush_valid=1:
  - load spec_head with the updated value of arch_head for that cycle, including same-cycle commits;
  - block allocation that cycle;
  - still process commits that cycle.
REQ-027 SHALL produce the same-cycle result free_count_next = free_count - allocs + frees when allocation and frees occur together.
REQ-028 SHALL flag an error in simulation (assertion) on a free with free_count = DEPTH, or with spec_head passing tail; RTL need not recover.
REQ-029 SHALL not check commits for preg 0 / lrd 0; upstream guarantees need_to_wb=0 for x0.
REQ-030 SHALL use 1 cycle from a commit free to that preg being visible to allocation.

Reset
REQ-031 SHALL, on reset_n low, set queue[i] = 32+i for i = 0..31, so pregs 32..63 are free and 0..31 hold the architectural mapping.
REQ-032 SHALL, on reset_n low, set spec_head = arch_head = 0 and tail = 32 (wrap bit set, index 0).
REQ-033 SHALL drive these outputs out of reset: free_count = 32, alloc_ready = 1, alloc0_preg = 32, alloc1_preg = 33.
REQ-034 SHALL restore reset state immediately on a reset asserted mid-operation, discarding all pointers and freed entries.

Verification
REQ-035 SHALL cover double allocation after reset: alloc0_req=alloc1_req=1 for one cycle -> next cycle alloc0_preg=34, alloc1_preg=35, free_count=30.
REQ-036 SHALL cover slot-1-only allocation: alloc1_req=1 alone at reset state -> alloc1_preg=32; next cycle free_count=31 and alloc0_preg=33.
REQ-037 SHALL cover exhaustion: 16 consecutive double allocations -> free_count=0, alloc_ready=0; further requests leave spec_head unchanged.
REQ-038 SHALL cover freeing after exhaustion: commits0 frees 5 and commits1 frees 7 in one cycle -> free_count=2, alloc_ready=1, alloc0_preg=5, alloc1_preg=7.
REQ-039 SHALL cover flush recovery:
  - Stimulus: allocate 2, then 1, then commit one write with old_prd=9 and assert flush_valid in the same cycle.
  - Required response: free_count=32 and alloc0_preg=33 (queue[1]).
REQ-040 SHALL cover simultaneous allocate and free: at free_count=2, double allocation plus two frees in the same cycle -> free_count stays 2, and the next pair granted is the two just-freed pregs.

Source files
------------

// File: rtl/freelist_if.sv
// Port bundle between rename/commit and the physical register free list.
// The master drives requests, commits and flush; the slave returns grants and the free count.
interface freelist_if #(
    parameter int PREG_W = 6,
    parameter int CNT_W  = 6
);
    logic              alloc0_req;
    logic              alloc1_req;
    logic              alloc_ready;
    logic [PREG_W-1:0] alloc0_preg;
    logic [PREG_W-1:0] alloc1_preg;
    logic              commits0_valid;
    logic              commits0_need_to_wb;
    logic [PREG_W-1:0] commits0_old_prd;
    logic              commits1_valid;
    logic              commits1_need_to_wb;
    logic [PREG_W-1:0] commits1_old_prd;
    logic              flush_valid;
    logic [CNT_W-1:0]  free_count;

    modport master (
        output alloc0_req, alloc1_req,
        output commits0_valid, commits0_need_to_wb, commits0_old_prd,
        output commits1_valid, commits1_need_to_wb, commits1_old_prd,
        output flush_valid,
        input  alloc_ready, alloc0_preg, alloc1_preg, free_count
    );

    modport slave (
        input  alloc0_req, alloc1_req,
        input  commits0_valid, commits0_need_to_wb, commits0_old_prd,
        input  commits1_valid, commits1_need_to_wb, commits1_old_prd,
        input  flush_valid,
        output alloc_ready, alloc0_preg, alloc1_preg, free_count
    );
endinterface

// File: rtl/freelist.sv
// Circular free list of physical registers for a 2-wide rename/commit pipeline.
// Speculative allocations roll back to the committed head on a flush.
module freelist #(
    parameter int NUM_PREGS = 64,
    parameter int DEPTH     = 32
) (
    input logic       clock,
    input logic       reset_n,
    freelist_if.slave fl
);
    localparam int PREG_W = $clog2(NUM_PREGS);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PTR_W-1:0]  ptr_t;

    preg_t      queue [DEPTH];
    ptr_t       spec_head;
    ptr_t       arch_head;
    ptr_t       tail;
    ptr_t       spec_head_next;
    ptr_t       arch_head_next;
    ptr_t       tail_next;
    ptr_t       spec_head_p1;
    ptr_t       tail_slot1;
    ptr_t       free_count;
    logic       free0;
    logic       free1;
    logic       grant;
    logic [1:0] num_free;
    logic [1:0] num_alloc;

    // Pointers carry a wrap bit so a full list (tail - head = DEPTH) is distinct from empty.
    assign free_count   = tail - spec_head;
    assign spec_head_p1 = spec_head + ptr_t'(1);

    assign fl.free_count  = free_count;
    assign fl.alloc_ready = (free_count >= ptr_t'(2));
    assign fl.alloc0_preg = queue[spec_head[IDX_W-1:0]];
    assign fl.alloc1_preg = fl.alloc0_req ? queue[spec_head_p1[IDX_W-1:0]]
                                          : queue[spec_head[IDX_W-1:0]];

    assign free0      = fl.commits0_valid & fl.commits0_need_to_wb;
    assign free1      = fl.commits1_valid & fl.commits1_need_to_wb;
    assign num_free   = {1'b0, free0} + {1'b0, free1};
    assign num_alloc  = {1'b0, fl.alloc0_req} + {1'b0, fl.alloc1_req};
    assign grant      = fl.alloc_ready & ~fl.flush_valid;
    assign tail_slot1 = free0 ? tail + ptr_t'(1) : tail;

    // Every writing commit retires one allocation, so arch_head tracks tail's advance;
    // a flush rewinds spec_head to that post-commit checkpoint.
    always_comb begin
        arch_head_next = arch_head + ptr_t'(num_free);
        tail_next      = tail + ptr_t'(num_free);
        spec_head_next = spec_head;
        if (fl.flush_valid) begin
            spec_head_next = arch_head_next;
        end else if (grant) begin
            spec_head_next = spec_head + ptr_t'(num_alloc);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            spec_head <= '0;
            arch_head <= '0;
            tail      <= ptr_t'(DEPTH);
        end else begin
            spec_head <= spec_head_next;
            arch_head <= arch_head_next;
            tail      <= tail_next;
        end
    end

    // Out of reset the upper pregs are free; the lower ones hold the architectural mapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                queue[i] <= preg_t'(NUM_PREGS - DEPTH + i);
            end
        end else begin
            if (free0) begin
                queue[tail[IDX_W-1:0]] <= fl.commits0_old_prd;
            end
            if (free1) begin
                queue[tail_slot1[IDX_W-1:0]] <= fl.commits1_old_prd;
            end
        end
    end

    free_when_full: assert property (@(posedge clock) disable iff (!reset_n)
        !((free0 || free1) && (free_count == ptr_t'(DEPTH))));

    head_past_tail: assert property (@(posedge clock) disable iff (!reset_n)
        free_count <= ptr_t'(DEPTH));
endmodule

// File: tb/tb_freelist.sv
// Bench for freelist: directed scenarios plus random traffic against a queue-based model
// of free and in-flight pregs.
module tb_freelist;
    logic clock = 1'b0;
    logic reset_n;
    int   total;
    int   bad;

    // free_q: pregs rename may take, oldest first; infl_q: speculative allocations not yet committed.
    logic [5:0] free_q[$];
    logic [5:0] infl_q[$];

    freelist_if fl ();

    freelist #(.NUM_PREGS(64), .DEPTH(32)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .fl     (fl)
    );

    always #5 clock = ~clock;

    task automatic set_idle();
        fl.alloc0_req          = 1'b0;
        fl.alloc1_req          = 1'b0;
        fl.commits0_valid      = 1'b0;
        fl.commits0_need_to_wb = 1'b0;
        fl.commits0_old_prd    = 6'd0;
        fl.commits1_valid      = 1'b0;
        fl.commits1_need_to_wb = 1'b0;
        fl.commits1_old_prd    = 6'd0;
        fl.flush_valid         = 1'b0;
    endtask

    task automatic model_reset();
        free_q.delete();
        infl_q.delete();
        for (int i = 0; i < 32; i++) free_q.push_back(6'(32 + i));
    endtask

    task automatic do_reset();
        @(negedge clock);
        set_idle();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic drive(input logic a0, input logic a1,
                         input logic v0, input logic w0, input logic [5:0] p0,
                         input logic v1, input logic w1, input logic [5:0] p1,
                         input logic flush);
        @(negedge clock);
        fl.alloc0_req          = a0;
        fl.alloc1_req          = a1;
        fl.commits0_valid      = v0;
        fl.commits0_need_to_wb = w0;
        fl.commits0_old_prd    = p0;
        fl.commits1_valid      = v1;
        fl.commits1_need_to_wb = w1;
        fl.commits1_old_prd    = p1;
        fl.flush_valid         = flush;
        #1;
    endtask

    // Clock edge plus model update from the stimulus the bench itself applied.
    task automatic advance();
        int   n_alloc;
        logic grant;
        @(posedge clock);
        grant   = (free_q.size() >= 2) && !fl.flush_valid;
        n_alloc = grant ? (int'(fl.alloc0_req) + int'(fl.alloc1_req)) : 0;
        for (int i = 0; i < n_alloc; i++) infl_q.push_back(free_q.pop_front());
        if (fl.commits0_valid && fl.commits0_need_to_wb) begin
            if (infl_q.size() > 0) void'(infl_q.pop_front());
            free_q.push_back(fl.commits0_old_prd);
        end
        if (fl.commits1_valid && fl.commits1_need_to_wb) begin
            if (infl_q.size() > 0) void'(infl_q.pop_front());
            free_q.push_back(fl.commits1_old_prd);
        end
        if (fl.flush_valid) begin
            while (infl_q.size() > 0) free_q.push_front(infl_q.pop_back());
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        set_idle();
        fl.alloc0_req = 1'b1;
        reset_n = 1'b0;
        #1;
        total++; if (fl.free_count !== 6'd32) begin bad++; $display("[TB] FAIL reset_free_count got=%0d want=32", fl.free_count); end
        total++; if (fl.alloc_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_alloc_ready got=%0b want=1", fl.alloc_ready); end
        total++; if (fl.alloc0_preg !== 6'd32) begin bad++; $display("[TB] FAIL reset_alloc0_preg got=%0d want=32", fl.alloc0_preg); end
        total++; if (fl.alloc1_preg !== 6'd33) begin bad++; $display("[TB] FAIL reset_alloc1_preg got=%0d want=33", fl.alloc1_preg); end
        fl.alloc0_req = 1'b0;
        #1;
        total++; if (fl.alloc1_preg !== 6'd32) begin bad++; $display("[TB] FAIL reset_alloc1_solo got=%0d want=32", fl.alloc1_preg); end
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_double_alloc();
        do_reset();
        drive(1, 1, 0, 0, 6'd0, 0, 0, 6'd0, 0);
        advance();
        drive(1, 1, 0, 0, 6'd0, 0, 0, 6'd0, 0);
        total++; if (fl.alloc0_preg !== 6'd34) begin bad++; $display("[TB] FAIL dbl_alloc0_preg got=%0d want=34", fl.alloc0_preg); end
        total++; if (fl.alloc1_preg !== 6'd35) begin bad++; $display("[TB] FAIL dbl_alloc1_preg got=%0d want=35", fl.alloc1_preg); end
        total++; if (fl.free_count !== 6'd30) begin bad++; $display("[TB] FAIL dbl_free_count got=%0d want=30", fl.free_count); end
        advance();
    endtask

    task automatic test_slot1_only();
        do_reset();
        drive(0, 1, 0, 0, 6'd0, 0, 0, 6'd0, 0);
        total++; if (fl.alloc1_preg !== 6'd32) begin bad++; $display("[TB] FAIL s1_alloc1_preg got=%0d want=32", fl.alloc1_preg); end
        advance();
        drive(1, 0, 0, 0, 6'd0, 0, 0, 6'd0, 0);
        total++; if (fl.free_count !== 6'd31) begin bad++; $display("[TB] FAIL s1_free_count got=%0d want=31", fl.free_count); end
        total++; if (fl.alloc0_preg !== 6'd33) begin bad++; $display("[TB] FAIL s1_alloc0_preg got=%0d want=33", fl.alloc0_preg); end
        advance();
    endtask

    task automatic test_exhaust_and_refill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, 0, 6'd0, 0, 0, 6'd0, 0);
            advance();
        end
        drive(1, 1, 0, 0, 6'd0, 0, 0, 6'd0, 0);
        total++; if (fl.free_count !== 6'd0) begin bad++; $display("[TB] FAIL exh_free_count got=%0d want=0", fl.free_count); end
        total++; if (fl.alloc_ready !== 1'b0) begin bad++; $display("[TB] FAIL exh_alloc_ready got=%0b want=0", fl.alloc_ready); end
        advance();
        drive(0, 0, 0, 0, 6'd0, 0, 0, 6'd0, 0);
        total++; if (fl.free_count !== 6'd0) begin bad++; $display("[TB] FAIL exh_ignored_req got=%0d want=0", fl.free_count); end
        advance();
        drive(0, 0, 1, 1, 6'd5, 1, 1, 6'd7, 0);
        advance();
        drive(1, 1, 1, 1, 6'd11, 1, 1, 6'd12, 0);
        total++; if (fl.free_count !== 6'd2) begin bad++; $display("[TB] FAIL refill_free_count got=%0d want=2", fl.free_count); end
        total++; if (fl.alloc_ready !== 1'b1) begin bad++; $display("[TB] FAIL refill_alloc_ready got=%0b want=1", fl.alloc_ready); end
        total++; if (fl.alloc0_preg !== 6'd5) begin bad++; $display("[TB] FAIL refill_alloc0_preg got=%0d want=5", fl.alloc0_preg); end
        total++; if (fl.alloc1_preg !== 6'd7) begin bad++; $display("[TB] FAIL refill_alloc1_preg got=%0d want=7", fl.alloc1_preg); end
        advance();
        drive(1, 1, 0, 0, 6'd0, 0, 0, 6'd0, 0);
        total++; if (fl.free_count !== 6'd2) begin bad++; $display("[TB] FAIL simul_free_count got=%0d want=2", fl.free_count); end
        total++; if (fl.alloc0_preg !== 6'd11) begin bad++; $display("[TB] FAIL simul_alloc0_preg got=%0d want=11", fl.alloc0_preg); end
        total++; if (fl.alloc1_preg !== 6'd12) begin bad++; $display("[TB] FAIL simul_alloc1_preg got=%0d want=12", fl.alloc1_preg); end
        advance();
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 1, 0, 0, 6'd0, 0, 0, 6'd0, 0);
        advance();
        drive(1, 0, 0, 0, 6'd0, 0, 0, 6'd0, 0);
        advance();
        drive(1, 1, 1, 1, 6'd9, 0, 0, 6'd0, 1);
        advance();
        drive(1, 1, 0, 0, 6'd0, 0, 0, 6'd0, 0);
        total++; if (fl.free_count !== 6'd32) begin bad++; $display("[TB] FAIL flush_free_count got=%0d want=32", fl.free_count); end
        total++; if (fl.alloc0_preg !== 6'd33) begin bad++; $display("[TB] FAIL flush_alloc0_preg got=%0d want=33", fl.alloc0_preg); end
        total++; if (fl.alloc1_preg !== 6'd34) begin bad++; $display("[TB] FAIL flush_alloc1_preg got=%0d want=34", fl.alloc1_preg); end
        advance();
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(1, 1, 0, 0, 6'd0, 0, 0, 6'd0, 0);
        advance();
        drive(1, 1, 0, 0, 6'd0, 0, 0, 6'd0, 0);
        advance();
        drive(0, 0, 1, 1, 6'd20, 0, 0, 6'd0, 0);
        reset_n = 1'b0;
        #1;
        total++; if (fl.free_count !== 6'd32) begin bad++; $display("[TB] FAIL midrst_free_count got=%0d want=32", fl.free_count); end
        total++; if (fl.alloc0_preg !== 6'd32) begin bad++; $display("[TB] FAIL midrst_alloc0_preg got=%0d want=32", fl.alloc0_preg); end
        set_idle();
        #1;
        reset_n = 1'b1;
        model_reset();
        drive(1, 1, 0, 0, 6'd0, 0, 0, 6'd0, 0);
        total++; if (fl.alloc1_preg !== 6'd33) begin bad++; $display("[TB] FAIL midrst_alloc1_preg got=%0d want=33", fl.alloc1_preg); end
        advance();
    endtask

    task automatic test_random();
        logic       a0, a1, v0, w0, v1, w1, f0, f1, flush;
        logic [5:0] p0, p1;
        int         exp_fc;
        int         idx1;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            a0    = 1'($urandom_range(0, 1));
            a1    = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 19) == 0);
            f0    = (infl_q.size() >= 1) && ($urandom_range(0, 2) == 0);
            f1    = (infl_q.size() >= (f0 ? 2 : 1)) && ($urandom_range(0, 2) == 0);
            v0    = f0 ? 1'b1 : 1'($urandom_range(0, 1));
            w0    = f0 ? 1'b1 : (v0 ? 1'b0 : 1'($urandom_range(0, 1)));
            v1    = f1 ? 1'b1 : 1'($urandom_range(0, 1));
            w1    = f1 ? 1'b1 : (v1 ? 1'b0 : 1'($urandom_range(0, 1)));
            p0    = 6'($urandom_range(0, 63));
            p1    = 6'($urandom_range(0, 63));
            drive(a0, a1, v0, w0, p0, v1, w1, p1, flush);
            exp_fc = free_q.size();
            total++; if (fl.free_count !== 6'(exp_fc)) begin bad++; $display("[TB] FAIL rnd_free_count cyc=%0d got=%0d want=%0d", cyc, fl.free_count, exp_fc); end
            total++; if (fl.alloc_ready !== (exp_fc >= 2)) begin bad++; $display("[TB] FAIL rnd_alloc_ready cyc=%0d got=%0b want=%0b", cyc, fl.alloc_ready, exp_fc >= 2); end
            if (exp_fc >= 1) begin
                total++; if (fl.alloc0_preg !== free_q[0]) begin bad++; $display("[TB] FAIL rnd_alloc0_preg cyc=%0d got=%0d want=%0d", cyc, fl.alloc0_preg, free_q[0]); end
            end
            idx1 = a0 ? 1 : 0;
            if (idx1 < exp_fc) begin
                total++; if (fl.alloc1_preg !== free_q[idx1]) begin bad++; $display("[TB] FAIL rnd_alloc1_preg cyc=%0d got=%0d want=%0d", cyc, fl.alloc1_preg, free_q[idx1]); end
            end
            advance();
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        set_idle();
        model_reset();
        #3;
        test_reset();
        test_double_alloc();
        test_slot1_only();
        test_exhaust_and_refill();
        test_flush();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
